// File: rtl/ram_reader.sv
// ram_reader: drains the dual-port sample RAM in the order the writer filled it.
// Occupancy is tracked from the writer's strobe. Each word is read on the RAM's
// second port and held on a valid/ready stream until the consumer accepts it.
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_wbit           writer strobe, one pulse per committed word
//   i_rdata          RAM read-port q (valid RD_LATENCY cycles after o_rden)
//   o_rd_address     RAM read address (always the current read pointer)
//   o_rden           RAM read enable, one cycle per word
//   o_data, o_valid  captured word and its valid flag
//   i_ready          consumer accept; a pop is o_valid & i_ready
//   o_overflow       sticky, set when a write arrives while the RAM is full
//
// Optional build macro RAM_READER_LEVEL_EN adds:
//   o_level          current occupancy
//   o_almost_full    occupancy >= depth - 16
//
// state | meaning
// IDLE  | nothing outstanding; waits for count != 0
// ISSUE | o_rden high for one cycle at rd_ptr
// WAIT  | waiting out the RAM read latency, captures q on the last cycle
// HOLD  | o_valid high, o_data stable until the consumer accepts
module ram_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 2,
  parameter int START_ADDR = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wbit,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] o_rd_address,
  output logic              o_rden,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overflow
`ifdef RAM_READER_LEVEL_EN
  ,
  output logic [ADDR_W:0]   o_level,
  output logic              o_almost_full
`endif
);

  localparam logic [ADDR_W:0]   FULL     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]        LAT_LOAD = 2'(RD_LATENCY - 1);
  localparam logic [ADDR_W-1:0] RST_PTR  = ADDR_W'(START_ADDR);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [1:0]        lat;
  logic              pop;
  logic              full;

  assign pop          = o_valid & i_ready;
  assign full         = (count == FULL);
  assign o_rd_address = rd_ptr;

  // A write and a pop on the same edge cancel, even when full: the slot freed
  // by the pop is taken by the write, so it is not an overflow.
  always_comb begin
    count_nxt = count;
    if (i_wbit && !pop && !full)
      count_nxt = count + 1'b1;
    else if (pop && !i_wbit)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (i_wbit && !pop && full)
        o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      rd_ptr  <= RST_PTR;
      lat     <= '0;
      o_rden  <= 1'b0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            o_rden <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          o_rden <= 1'b0;
          lat    <= LAT_LOAD;
          state  <= WAIT;
        end
        WAIT: begin
          // lat reaches zero in the cycle the RAM q carries the requested word
          if (lat == 2'd0) begin
            o_data  <= i_rdata;
            o_valid <= 1'b1;
            state   <= HOLD;
          end else begin
            lat <= lat - 2'd1;
          end
        end
        HOLD: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            rd_ptr  <= rd_ptr + 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_READER_LEVEL_EN
  localparam logic [ADDR_W:0] AF_LEVEL = FULL - (ADDR_W+1)'(16);

  assign o_level = count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_almost_full <= 1'b0;
    else
      o_almost_full <= (count_nxt >= AF_LEVEL);
  end
`endif

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader. A small RAM + writer model feeds the DUT; a monitor on
// the falling edge keeps a FIFO-level reference (queue of written addresses and
// words, occupancy, sticky overflow) and checks every read address, every held
// word and the read latency. The RAM is shrunk to 256 words so wrap and
// full/overflow scenarios stay short.
module tb_ram_reader;
  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int LAT   = 2;
  localparam int SA    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 0;
  logic          i_rst = 1;
  logic          i_wbit = 0;
  logic          i_ready = 0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] i_rdata;
  logic [AW-1:0] o_rd_address;
  logic          o_rden;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_overflow;
`ifdef RAM_READER_LEVEL_EN
  logic [AW:0]   o_level;
  logic          o_almost_full;
`endif

  ram_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .START_ADDR(SA)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_wbit(i_wbit), .i_rdata(i_rdata),
    .o_rd_address(o_rd_address), .o_rden(o_rden), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_overflow(o_overflow)
`ifdef RAM_READER_LEVEL_EN
    , .o_level(o_level), .o_almost_full(o_almost_full)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // RAM and writer model: write pointer starts at SA, read has LAT cycles latency.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wa;
  logic [DW-1:0] pipe [LAT];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_rst) wa <= AW'(SA);
    else if (i_wbit) begin
      mem[wa] <= wdata;
      wa      <= wa + 1'b1;
    end
    pipe[0] <= o_rden ? mem[o_rd_address] : {$urandom, $urandom};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign i_rdata = pipe[LAT-1];

  // Reference model: words leave in the order they were accepted.
  logic [AW-1:0] aq[$];
  logic [DW-1:0] dq[$];
  int m_count = 0;
  bit m_ovf = 0;
  bit prev_valid = 0;
  int rden_cyc = 0;
  int n_rden = 0;

  always @(negedge clk) begin
    bit pop, acc;
    if (i_rst) begin
      m_count = 0; m_ovf = 0; prev_valid = 0;
      aq.delete(); dq.delete();
    end else begin
      chk("overflow", o_overflow, m_ovf);
      chk("count", dut.count, m_count);
`ifdef RAM_READER_LEVEL_EN
      chk("level", o_level, m_count);
`endif
      if (o_rden) begin
        n_rden++;
        rden_cyc = cyc;
        chk("rd_expected", aq.size() != 0, 1);
        if (aq.size() != 0) chk("rd_addr", o_rd_address, aq.pop_front());
      end
      if (o_valid) begin
        if (!prev_valid) chk("latency", cyc, rden_cyc + LAT + 1);
        chk("valid_expected", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          chk("data", o_data, dq[0]);
          if (i_ready) void'(dq.pop_front());
        end
      end
      prev_valid = o_valid;
      pop = o_valid & i_ready;
      acc = i_wbit && (m_count < DEPTH || pop);
      if (i_wbit && !acc) m_ovf = 1;
      if (acc) begin
        aq.push_back(wa);
        dq.push_back(wdata);
      end
      m_count = m_count + int'(acc) - int'(pop);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr();
    i_wbit = 1;
    wdata  = {$urandom, $urandom};
    tick();
    i_wbit = 0;
  endtask

  task automatic do_reset();
    i_rst = 1; i_wbit = 0; i_ready = 0;
    tick(); tick();
    i_rst = 0;
    tick();
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_valid && n < 100) begin tick(); n++; end
    chk("wait_valid", o_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    i_ready = 1;
    while ((dq.size() != 0 || o_valid) && n < 4000) begin tick(); n++; end
    chk("drain_done", (dq.size() == 0) && !o_valid, 1);
  endtask

  initial begin
    int wrote;
    logic [DW-1:0] first;

    tick(); tick();
    chk("rst_rden", o_rden, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_addr", o_rd_address, SA);
    i_rst = 0;
    tick();

    // single word
    i_ready = 1;
    wr();
    drain();
    chk("single_ptr", o_rd_address, SA + 1);
    chk("single_count", dut.count, 0);

    // backpressure
    do_reset();
    n_rden = 0;
    wr(); first = wdata;
    wr(); wr();
    repeat (20) tick();
    chk("bp_valid", o_valid, 1);
    chk("bp_data", o_data, first);
    chk("bp_rden_once", n_rden, 1);
    drain();
    chk("bp_rden_total", n_rden, 3);
    chk("bp_ptr", o_rd_address, SA + 3);

    // random traffic up to the last address, then wrap
    do_reset();
    wrote = 0;
    while (wrote < DEPTH - 3) begin
      i_ready = ($urandom % 4) != 0;
      i_wbit  = $urandom % 2;
      if (i_wbit) begin wdata = {$urandom, $urandom}; wrote++; end
      tick();
    end
    i_wbit = 0;
    drain();
    chk("pre_wrap_ptr", o_rd_address, DEPTH - 1);
    wr(); wr();
    drain();
    chk("post_wrap_ptr", o_rd_address, 1);

    // simultaneous write and pop with one word stored
    do_reset();
    wr();
    wait_valid();
    i_ready = 1; i_wbit = 1; wdata = {$urandom, $urandom};
    tick();
    i_ready = 0; i_wbit = 0;
    chk("simul_count", dut.count, 1);
    drain();
    chk("simul_ptr", o_rd_address, SA + 2);

    // fill to full, then overflow, then write+pop while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr();
    chk("full_ovf", o_overflow, 0);
    chk("full_count", dut.count, DEPTH);
    wr();
    chk("ovf_set", o_overflow, 1);
    chk("ovf_count", dut.count, DEPTH);
    i_ready = 1; i_wbit = 1; wdata = {$urandom, $urandom};
    tick();
    i_ready = 0; i_wbit = 0;
    chk("ovf_simul_count", dut.count, DEPTH);
    chk("ovf_sticky", o_overflow, 1);

    // async reset during the read-latency wait
    do_reset();
    i_ready = 1;
    wr();
    begin
      int n = 0;
      while (!o_rden && n < 20) begin tick(); n++; end
      chk("saw_rden", o_rden, 1);
    end
    tick();
    #2 i_rst = 1;
    #1;
    chk("arst_rden", o_rden, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_data", o_data, 0);
    chk("arst_ovf", o_overflow, 0);
    chk("arst_addr", o_rd_address, SA);
    tick(); tick();
    i_rst = 0;
    repeat (10) tick();
    chk("no_valid_after_rst", o_valid, 0);
    wr();
    drain();
    chk("rst_then_ptr", o_rd_address, SA + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
